// File: rtl/pipelined_barrel_shifter.sv
// Log2-staged barrel shifter/rotator with a valid/ready handshake.
// Stage s applies a 2^s shift when bit s of the amount is set; every stage holds together on stall.
module pipelined_barrel_shifter #(
    parameter int BW_DATA = 8,
    parameter int BW_CTRL = $clog2(BW_DATA)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [BW_DATA-1:0] i_a,
    input  logic [BW_CTRL-1:0] i_k,
    input  logic               i_left,
    input  logic [1:0]         i_mode,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [BW_DATA-1:0] o_y
);

    localparam logic [1:0] MODE_ROT = 2'b00;
    localparam logic [1:0] MODE_ASH = 2'b10;
    localparam logic [1:0] MODE_ONE = 2'b11;

    logic adv;

    assign adv     = !o_valid || i_ready;
    assign o_ready = adv;

    genvar s;
    generate
        for (s = 0; s < BW_CTRL; s++) begin : g_stage
            localparam int SH = 1 << s;
            localparam int KW = BW_CTRL - s;
            localparam logic [BW_DATA-1:0] LO_FILL = {BW_DATA{1'b1}} >> (BW_DATA - SH);
            localparam logic [BW_DATA-1:0] HI_FILL = ~({BW_DATA{1'b1}} >> SH);

            logic [BW_DATA-1:0] d_in;
            logic [BW_DATA-1:0] d_sh;
            logic [BW_DATA-1:0] d_q;
            logic               v_in;
            logic               v_q;
            logic               l_in;
            logic [1:0]         m_in;
            logic [KW-1:0]      k_in;
            logic               fill;

            if (s == 0) begin : g_src
                assign d_in = i_a;
                assign v_in = i_valid;
                assign l_in = i_left;
                assign m_in = i_mode;
                assign k_in = i_k;
            end else begin : g_src
                assign d_in = g_stage[s-1].d_q;
                assign v_in = g_stage[s-1].v_q;
                assign l_in = g_stage[s-1].g_ctl.l_q;
                assign m_in = g_stage[s-1].g_ctl.m_q;
                assign k_in = g_stage[s-1].g_ctl.k_q;
            end

            // Arithmetic right fill uses the current MSB: it still equals the operand sign.
            always_comb begin
                fill = (m_in == MODE_ONE) ||
                       ((m_in == MODE_ASH) && !l_in && d_in[BW_DATA-1]);
                d_sh = d_in;
                if (k_in[0]) begin
                    if (m_in == MODE_ROT) begin
                        d_sh = l_in ? ((d_in << SH) | (d_in >> (BW_DATA - SH)))
                                    : ((d_in >> SH) | (d_in << (BW_DATA - SH)));
                    end else begin
                        d_sh = l_in ? ((d_in << SH) | (fill ? LO_FILL : '0))
                                    : ((d_in >> SH) | (fill ? HI_FILL : '0));
                    end
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    v_q <= 1'b0;
                end else if (adv) begin
                    v_q <= v_in;
                    d_q <= d_sh;
                end
            end

            // The last stage has no downstream consumer of the control bits.
            if (s < BW_CTRL - 1) begin : g_ctl
                logic          l_q;
                logic [1:0]    m_q;
                logic [KW-2:0] k_q;

                always_ff @(posedge i_clk) begin
                    if (adv) begin
                        l_q <= l_in;
                        m_q <= m_in;
                        k_q <= k_in[KW-1:1];
                    end
                end
            end
        end
    endgenerate

    assign o_valid = g_stage[BW_CTRL-1].v_q;
    assign o_y     = o_valid ? g_stage[BW_CTRL-1].d_q : '0;

endmodule
